clock_counter: RTL
==================

CLOCK_COUNTER -- requirements
Module: clock_counter

Interface
REQ-001 SHALL have port clk_in  input  1  system clock; all state on its rising edge.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port tick_in  input  1  divided time base from the clock divider; any duty cycle; each rising edge = one second.
REQ-004 SHALL have port btn_mode  input  1  debounced mode button, level, synchronous to clk_in.
REQ-005 SHALL have port btn_inc  input  1  debounced increment button, level, synchronous to clk_in.
REQ-006 SHALL have port sec_bcd  output  8  seconds, two BCD digits, 00-59.
REQ-007 SHALL have port min_bcd  output  8  minutes, two BCD digits, 00-59.
REQ-008 SHALL have port hour_bcd  output  8  hours, two BCD digits; 00-23, or 01-12 with HOUR_12_EN.
REQ-009 SHALL have port mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-010 SHALL have port sec_pulse  output  1  one-clk_in pulse per accepted second tick.
REQ-011 SHALL have port pm  output  1  PM flag; constant 0 without HOUR_12_EN.

Function
REQ-012 SHALL register tick_in and raise an internal event for exactly one clk_in cycle on each 0->1 transition; 1 cycle latency from sampled edge to event.
REQ-013 SHALL detect btn_mode and btn_inc rising edges the same way; held buttons produce one event only.
REQ-014 SHALL in RUN, on tick event, increment sec_bcd; 59->00 carries to minutes; minute 59->00 carries to hours; all carries complete in the same cycle.
REQ-015 SHALL wrap hours 23->00 (24 h build).
REQ-016 SHALL keep each BCD nibble within 0-9; digit carry 09->10, 59->00; no illegal codes ever visible.
REQ-017 SHALL pulse sec_pulse with every tick event accepted in RUN, coincident with the sec_bcd update.
REQ-018 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing on each btn_mode event.
REQ-019 SHALL in SET_HOUR, on btn_inc event, increment hours with wrap, no carry to other fields.
REQ-020 SHALL in SET_MIN, on btn_inc event, increment minutes with wrap 59->00, no carry to hours, and clear sec_bcd to 00.
REQ-021 SHALL ignore tick events in SET_HOUR and SET_MIN (time frozen, sec_pulse low).
REQ-022 SHALL, on simultaneous btn_mode and btn_inc events, apply btn_mode only.
REQ-023 SHALL, on simultaneous tick and btn_mode event in RUN, apply the tick then leave RUN.
REQ-024 SHALL, when leaving SET_MIN to RUN, resume counting at the next tick event.

Reset
REQ-025 SHALL on rst low immediately force sec_bcd=00, min_bcd=00, hour_bcd=00 (12 in 12 h build), mode=RUN, sec_pulse=0, pm=0, edge registers=0.
REQ-026 SHALL, after rst deasserts with tick_in already high, not count a second until tick_in falls and rises again.
REQ-027 SHALL abort any set mode on reset mid-operation; no partial update retained.

Configuration
REQ-028 SHALL use macro HOUR_12_EN: defined -> hours 12,01..11 cycle; 11->12 toggles pm; inc in SET_HOUR follows same sequence incl. pm toggle; reset 12 AM.
REQ-029 SHALL, without HOUR_12_EN, use 24 h range 00-23 and tie pm to 0.

Verification
REQ-030 SHALL cover: reset, 60 tick_in rising edges -> sec_bcd 00, min_bcd 01, 60 sec_pulse pulses.
REQ-031 SHALL cover: time preset 23:59:59 via set mode and ticks, one tick -> 00:00:00 (12 h build: 11:59:59 PM -> 12:00:00 AM, pm=0).
REQ-032 SHALL cover: btn_mode once, btn_inc held 100 cycles -> hour_bcd +1 exactly; ticks meanwhile -> sec_bcd unchanged.
REQ-033 SHALL cover: SET_MIN at 59, btn_inc -> min_bcd 00, hour_bcd unchanged, sec_bcd 00.
REQ-034 SHALL cover: btn_mode and btn_inc same cycle in RUN -> mode 01, hour unchanged.
REQ-035 SHALL cover: rst pulse mid SET_HOUR with tick_in high -> all zero, mode 00, no count until next tick_in rising edge.

Source files
------------

// File: rtl/clock_counter.sv
// Real-time clock counter: BCD seconds/minutes/hours with a RUN/SET_HOUR/SET_MIN setting FSM.
// Optional macro HOUR_12_EN selects the 12 h (12,01..11 + pm) hour sequence; default build is 24 h.
module clock_counter (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] mode,
    output logic       sec_pulse,
    output logic       pm
);

    localparam int unsigned BCD_W  = 8;
    localparam int unsigned N_IN   = 3;
    localparam int unsigned IX_TCK = 0;
    localparam int unsigned IX_MOD = 1;
    localparam int unsigned IX_INC = 2;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

`ifdef HOUR_12_EN
    localparam logic [BCD_W-1:0] HOUR_RST = 8'h12;
`else
    localparam logic [BCD_W-1:0] HOUR_RST = 8'h00;
`endif

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v[3:0] == 4'd9) return {4'(v[7:4] + 4'd1), 4'd0};
        else                return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc60(input logic [BCD_W-1:0] v);
        return (v == 8'h59) ? 8'h00 : bcd_inc(v);
    endfunction

    logic [N_IN-1:0]  raw_c, in_q, in_prev_q, armed_q, ev_c;
    logic             tick_ev_c, mode_ev_c, inc_ev_c;
    mode_e            state_q, state_d;
    logic [BCD_W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [BCD_W-1:0] hour_inc_c;
    logic             pm_q, pm_d, pm_tgl_c, pulse_q, pulse_d;

    // An input is armed only after it has been seen low, so a level held high through reset never fires.
    assign raw_c     = {btn_inc, btn_mode, tick_in};
    assign ev_c      = in_q & ~in_prev_q & armed_q;
    assign tick_ev_c = ev_c[IX_TCK];
    assign mode_ev_c = ev_c[IX_MOD];
    assign inc_ev_c  = ev_c[IX_INC];

`ifdef HOUR_12_EN
    always_comb begin
        hour_inc_c = (hour_q == 8'h12) ? 8'h01 : bcd_inc(hour_q);
        pm_tgl_c   = (hour_q == 8'h11);
    end
`else
    always_comb begin
        hour_inc_c = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
        pm_tgl_c   = 1'b0;
    end
`endif

    // Next-state: mode has priority over inc; a tick in RUN still lands in the cycle RUN is left.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        pm_d    = pm_q;
        pulse_d = 1'b0;
        case (state_q)
            RUN: begin
                if (tick_ev_c) begin
                    pulse_d = 1'b1;
                    sec_d   = bcd_inc60(sec_q);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc60(min_q);
                        if (min_q == 8'h59) begin
                            hour_d = hour_inc_c;
                            pm_d   = pm_q ^ pm_tgl_c;
                        end
                    end
                end
                if (mode_ev_c) state_d = SET_HOUR;
            end
            SET_HOUR: begin
                if (mode_ev_c) begin
                    state_d = SET_MIN;
                end else if (inc_ev_c) begin
                    hour_d = hour_inc_c;
                    pm_d   = pm_q ^ pm_tgl_c;
                end
            end
            SET_MIN: begin
                if (mode_ev_c) begin
                    state_d = RUN;
                end else if (inc_ev_c) begin
                    min_d = bcd_inc60(min_q);
                    sec_d = 8'h00;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            in_q      <= '0;
            in_prev_q <= '0;
            armed_q   <= '0;
            state_q   <= RUN;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_q    <= HOUR_RST;
            pm_q      <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            in_q      <= raw_c;
            in_prev_q <= in_q;
            armed_q   <= armed_q | ~raw_c;
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            pm_q      <= pm_d;
            pulse_q   <= pulse_d;
        end
    end

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign hour_bcd  = hour_q;
    assign mode      = state_q;
    assign sec_pulse = pulse_q;
    assign pm        = pm_q;

endmodule
